i2c_master_ctrl: RTL

//  Single-master I2C initiator. Drives SCL and SDA toward the on-board I2C slave register port.
//  One command issues one transaction: START, {DevID,R/W}, ACK, RegAddr, ACK, data byte, 9th bit, STOP.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_tick_gen.sv | 28 ++
 rtl/i2c_master_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the single-master I2C initiator: FSM state codes,
// byte-slot indices and default parameters.
package i2c_pkg;

  localparam int         QUARTER_DEFAULT = 62;
  localparam logic [6:0] DEFAULT_DEV_ID  = 7'd5;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START_A = 4'd1;
  localparam logic [3:0] S_START_B = 4'd2;
  localparam logic [3:0] S_BIT_Q0  = 4'd3;
  localparam logic [3:0] S_BIT_Q1  = 4'd4;
  localparam logic [3:0] S_BIT_Q2  = 4'd5;
  localparam logic [3:0] S_BIT_Q3  = 4'd6;
  localparam logic [3:0] S_STOP_A  = 4'd7;
  localparam logic [3:0] S_STOP_B  = 4'd8;
  localparam logic [3:0] S_STOP_C  = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  localparam logic [1:0] BYTE_ADDR = 2'd0;
  localparam logic [1:0] BYTE_DATA = 2'd2;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period timebase: one-cycle tick on the last cycle of every quarter
// while enabled; the counter sits at zero whenever disabled.
module i2c_tick_gen #(
  parameter int QUARTER = 62
) (
  input  logic CLK,
  input  logic Reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(QUARTER - 1));

  always_comb begin
    if (!en_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C initiator: START, {DevID,RW}, RegAddr, one data byte
// (write or read, no repeated START), STOP. Each FSM state lasts one quarter.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int QUARTER = QUARTER_DEFAULT
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRW,
  input  logic [6:0] iDevID,
  input  logic [7:0] iRegAddr,
  input  logic [7:0] iWData,
  input  logic       iSDA,
  output logic       SCL,
  output logic       oSDA,
  output logic [7:0] oRData,
  output logic       oBusy,
  output logic       oDone,
  output logic       oAckErr
);

  logic [3:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_q, byte_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_err_q, ack_err_d;

  logic busy, accept, tick, ninth, reading, bit_val;

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign accept  = iStart && !busy;
  assign ninth   = (bit_cnt_q == 4'd0);
  assign reading = rw_q && (byte_q == BYTE_DATA);
  // Master releases SDA for every 9th bit and for all bits of the read byte.
  assign bit_val = (ninth || reading) ? 1'b1 : shift_q[7];

  i2c_tick_gen #(.QUARTER(QUARTER)) u_tick (
    .CLK    (CLK),
    .Reset  (Reset),
    .en_i   (busy),
    .tick_o (tick)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latches).
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d   = S_START_A;
          rw_d      = iRW;
          dev_d     = iDevID;
          reg_d     = iRegAddr;
          wdata_d   = iWData;
          ack_err_d = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_START_A: if (tick) state_d = S_START_B;
      S_START_B: if (tick) begin
        state_d   = S_BIT_Q0;
        bit_cnt_d = 4'd8;
        shift_d   = {dev_q, rw_q};
        byte_d    = BYTE_ADDR;
      end
      S_BIT_Q0: if (tick) state_d = S_BIT_Q1;
      S_BIT_Q1: if (tick) state_d = S_BIT_Q2;
      S_BIT_Q2: if (tick) begin
        state_d = S_BIT_Q3;
        if (!ninth && reading)       shift_d   = {shift_q[6:0], iSDA};
        else if (ninth && !reading && iSDA) ack_err_d = 1'b1;
      end
      S_BIT_Q3: if (tick) begin
        if (!ninth) begin
          state_d   = S_BIT_Q0;
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (!reading) shift_d = {shift_q[6:0], 1'b0};
        end else begin
          if (reading) rdata_d = shift_q;
          if (ack_err_q || byte_q == BYTE_DATA) begin
            state_d = S_STOP_A;
          end else begin
            state_d   = S_BIT_Q0;
            bit_cnt_d = 4'd8;
            byte_d    = byte_q + 2'd1;
            shift_d   = (byte_q == BYTE_ADDR) ? reg_q : wdata_q;
          end
        end
      end
      S_STOP_A: if (tick) state_d = S_STOP_B;
      S_STOP_B: if (tick) state_d = S_STOP_C;
      S_STOP_C: if (tick) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    SCL  = 1'b1;
    oSDA = 1'b1;
    case (state_q)
      S_START_A: begin SCL = 1'b1; oSDA = 1'b0;    end
      S_START_B: begin SCL = 1'b0; oSDA = 1'b0;    end
      S_BIT_Q0:  begin SCL = 1'b0; oSDA = bit_val; end
      S_BIT_Q1:  begin SCL = 1'b1; oSDA = bit_val; end
      S_BIT_Q2:  begin SCL = 1'b1; oSDA = bit_val; end
      S_BIT_Q3:  begin SCL = 1'b0; oSDA = bit_val; end
      S_STOP_A:  begin SCL = 1'b0; oSDA = 1'b0;    end
      S_STOP_B:  begin SCL = 1'b1; oSDA = 1'b0;    end
      default:   begin SCL = 1'b1; oSDA = 1'b1;    end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      byte_q    <= BYTE_ADDR;
      rw_q      <= 1'b0;
      dev_q     <= DEFAULT_DEV_ID;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign oRData  = rdata_q;
  assign oBusy   = busy;
  assign oDone   = (state_q == S_DONE);
  assign oAckErr = ack_err_q;

endmodule
